fifo_word_unpacker: RTL

//  Read-side consumer of the 8-in/32-out byte FIFO. Pops one packed word when the FIFO

---
 rtl/w2b_pkg.sv | 12 +
 rtl/fifo_word_unpacker_if.sv | 49 ++++
 rtl/w2b_byte_select.sv | 23 ++
 rtl/fifo_word_unpacker.sv | 85 ++++++++
 4 files changed

// File: rtl/w2b_pkg.sv
// Shared types and helpers for the word-to-byte unpacker.
package w2b_pkg;

    typedef enum logic {W2B_IDLE, W2B_SEND} w2b_state_e;

    localparam w2b_state_e W2B_STATE_RST = W2B_IDLE;

    function automatic int unsigned w2b_idx_w(input int unsigned bytes_per_word);
        return $clog2(bytes_per_word);
    endfunction

endpackage

// File: rtl/fifo_word_unpacker_if.sv
// Upstream FIFO read port plus byte-stream output of the unpacker.
// Optional m_last exists only when W2B_LAST_EN is defined.
interface fifo_word_unpacker_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned BYTES_PER_WORD = 4
);
    localparam int unsigned READ_WIDTH = BYTES_PER_WORD * DATA_WIDTH;

    logic [READ_WIDTH-1:0] s_data;
    logic                  s_empty;
    logic                  s_rd_en;
    logic                  flush;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  busy;
`ifdef W2B_LAST_EN
    logic                  m_last;
`endif

    modport slave (
        input  s_data,
        input  s_empty,
        input  flush,
        input  m_ready,
        output s_rd_en,
        output m_data,
        output m_valid,
`ifdef W2B_LAST_EN
        output m_last,
`endif
        output busy
    );

    modport master (
        output s_data,
        output s_empty,
        output flush,
        output m_ready,
        input  s_rd_en,
        input  m_data,
        input  m_valid,
`ifdef W2B_LAST_EN
        input  m_last,
`endif
        input  busy
    );

endinterface

// File: rtl/w2b_byte_select.sv
// Combinational byte lane select: picks byte idx out of a packed word.
module w2b_byte_select
    import w2b_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned IDX_W          = w2b_idx_w(BYTES_PER_WORD)
) (
    input  logic [BYTES_PER_WORD*DATA_WIDTH-1:0] word,
    input  logic [IDX_W-1:0]                     idx,
    output logic [DATA_WIDTH-1:0]                sel_byte
);

    always_comb begin
        sel_byte = '0;
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_byte = word[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/fifo_word_unpacker.sv
// Pops packed words from the byte FIFO and replays them one byte per clock.
// Build option W2B_LAST_EN adds m_last, marking the final byte of each word.
module fifo_word_unpacker
    import w2b_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned READ_WIDTH     = BYTES_PER_WORD * DATA_WIDTH
) (
    input logic                 clk,
    input logic                 rst_n,
    fifo_word_unpacker_if.slave bus
);

    localparam int unsigned IDX_W = w2b_idx_w(BYTES_PER_WORD);

    w2b_state_e            state_q;
    logic [READ_WIDTH-1:0] hold_q;
    logic [IDX_W-1:0]      idx_q;

    logic valid;
    logic take;
    logic last;
    logic pop;

    assign valid = (state_q == W2B_SEND);
    assign take  = valid && bus.m_ready;
    assign last  = (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    // rst_n gating keeps the upstream untouched while reset is held
    assign pop   = rst_n && !bus.flush && !bus.s_empty &&
                   ((state_q == W2B_IDLE) || (take && last));

    assign bus.s_rd_en = pop;
    assign bus.m_valid = valid;
    assign bus.busy    = valid;
`ifdef W2B_LAST_EN
    assign bus.m_last  = valid && last;
`endif

    w2b_byte_select #(
        .DATA_WIDTH     (DATA_WIDTH),
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .IDX_W          (IDX_W)
    ) u_byte_select (
        .word     (hold_q),
        .idx      (idx_q),
        .sel_byte (bus.m_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= W2B_STATE_RST;
            hold_q  <= '0;
            idx_q   <= '0;
        end else if (bus.flush) begin
            state_q <= W2B_IDLE;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                W2B_IDLE: begin
                    if (pop) begin
                        hold_q  <= bus.s_data;
                        idx_q   <= '0;
                        state_q <= W2B_SEND;
                    end
                end
                W2B_SEND: begin
                    if (take) begin
                        if (!last) begin
                            idx_q <= idx_q + IDX_W'(1);
                        end else if (pop) begin
                            // reload on the last take so the stream has no bubble
                            hold_q <= bus.s_data;
                            idx_q  <= '0;
                        end else begin
                            state_q <= W2B_IDLE;
                            idx_q   <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
